// File: rtl/posit_decoder_pipe.sv
// Two-stage pipelined posit field decoder with valid/ready on both sides.
// Optional `scale` output (regime*2^ES + exponent) when POSIT_DEC_SCALE_EN is defined.

package posit_pkg;
    typedef enum logic {
        POS = 1'b0,
        NEG = 1'b1
    } sign_t;
endpackage

module posit_decoder_pipe #(
    parameter int WIDTH = 8,
    parameter int ES    = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             posit,
    output logic                         out_valid,
    input  logic                         out_ready,
    output posit_pkg::sign_t             sign,
    output logic signed [7:0]            regime,
    output logic [((ES > 0) ? ES : 1)-1:0] exponent,
    output logic [WIDTH-ES-3:0]          mantissa,
`ifdef POSIT_DEC_SCALE_EN
    output logic signed [8+ES-1:0]       scale,
`endif
    output logic                         is_zero,
    output logic                         is_nar
);
    import posit_pkg::*;

    localparam int MANT_W  = WIDTH - ES - 2;
    localparam int EXP_W   = (ES > 0) ? ES : 1;
    localparam int SCALE_W = 8 + ES;

    // Stage S1: sign, magnitude below the sign bit, raw-word flags
    logic             s1_valid_q, s1_valid_d;
    sign_t            s1_sign_q,  s1_sign_d;
    logic [WIDTH-2:0] s1_rem_q,   s1_rem_d;
    logic             s1_zero_q,  s1_zero_d;
    logic             s1_nar_q,   s1_nar_d;

    // Stage S2: decoded fields, driven straight onto the outputs
    logic               out_valid_q, out_valid_d;
    sign_t              sign_q,      sign_d;
    logic signed [7:0]  regime_q,    regime_d;
    logic [EXP_W-1:0]   exponent_q,  exponent_d;
    logic [MANT_W-1:0]  mantissa_q,  mantissa_d;
    logic               is_zero_q,   is_zero_d;
    logic               is_nar_q,    is_nar_d;
    logic signed [SCALE_W-1:0] scale_q, scale_d;

    logic s2_ready;

    // Field extraction from the S1 register
    logic                      first;
    logic                      run_done;
    int                        run_len;
    logic [WIDTH-2:0]          shifted;
    logic [WIDTH-1:0]          mant_full;
    logic signed [7:0]         dec_regime;
    logic [EXP_W-1:0]          dec_exp;
    logic [MANT_W-1:0]         dec_mant;
    logic signed [SCALE_W-1:0] dec_scale;

    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        first    = s1_rem_q[WIDTH-2];
        run_len  = 0;
        run_done = 1'b0;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            if (!run_done) begin
                if (s1_rem_q[i] == first) run_len++;
                else                      run_done = 1'b1;
            end
        end
        // Drop the run and its terminator; bits shifted in past the LSB are zero.
        shifted    = s1_rem_q << (run_len + 1);
        dec_exp    = EXP_W'(shifted >> (WIDTH - 1 - ES));
        mant_full  = {1'b1, shifted << ES};
        dec_mant   = mant_full[WIDTH-1 -: MANT_W];
        dec_regime = first ? 8'(run_len - 1) : 8'(-run_len);
        dec_scale  = SCALE_W'((int'(dec_regime) * (2 ** ES)) + int'(dec_exp));
    end

    // Each stage loads when empty or when its content leaves this cycle.
    assign s2_ready = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_rem_d   = s1_rem_q;
        s1_zero_d  = s1_zero_q;
        s1_nar_d   = s1_nar_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d = posit[WIDTH-1] ? NEG : POS;
                s1_rem_d  = posit[WIDTH-1] ? -posit[WIDTH-2:0] : posit[WIDTH-2:0];
                s1_zero_d = (posit == '0);
                s1_nar_d  = (posit == {1'b1, {(WIDTH-1){1'b0}}});
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        sign_d      = sign_q;
        regime_d    = regime_q;
        exponent_d  = exponent_q;
        mantissa_d  = mantissa_q;
        is_zero_d   = is_zero_q;
        is_nar_d    = is_nar_q;
        scale_d     = scale_q;
        if (s2_ready) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                is_zero_d = s1_zero_q;
                is_nar_d  = s1_nar_q;
                if (s1_zero_q || s1_nar_q) begin
                    sign_d     = POS;
                    regime_d   = '0;
                    exponent_d = '0;
                    mantissa_d = '0;
                    scale_d    = '0;
                end else begin
                    sign_d     = s1_sign_q;
                    regime_d   = dec_regime;
                    exponent_d = dec_exp;
                    mantissa_d = dec_mant;
                    scale_d    = dec_scale;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= POS;
            s1_rem_q    <= '0;
            s1_zero_q   <= 1'b0;
            s1_nar_q    <= 1'b0;
            out_valid_q <= 1'b0;
            sign_q      <= POS;
            regime_q    <= '0;
            exponent_q  <= '0;
            mantissa_q  <= '0;
            is_zero_q   <= 1'b0;
            is_nar_q    <= 1'b0;
            scale_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_rem_q    <= s1_rem_d;
            s1_zero_q   <= s1_zero_d;
            s1_nar_q    <= s1_nar_d;
            out_valid_q <= out_valid_d;
            sign_q      <= sign_d;
            regime_q    <= regime_d;
            exponent_q  <= exponent_d;
            mantissa_q  <= mantissa_d;
            is_zero_q   <= is_zero_d;
            is_nar_q    <= is_nar_d;
            scale_q     <= scale_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sign      = sign_q;
    assign regime    = regime_q;
    assign exponent  = exponent_q;
    assign mantissa  = mantissa_q;
    assign is_zero   = is_zero_q;
    assign is_nar    = is_nar_q;
`ifdef POSIT_DEC_SCALE_EN
    assign scale     = scale_q;
`else
    logic unused_scale;
    assign unused_scale = ^scale_q;
`endif

endmodule

// File: tb/tb_posit_decoder_pipe.sv
// Bench for posit_decoder_pipe (WIDTH=8, ES=1): bit-queue reference model, scoreboard
// monitor on the falling edge, directed vectors, stall and mid-stream reset scenarios.

module tb_posit_decoder_pipe;
    import posit_pkg::*;

    localparam int WIDTH  = 8;
    localparam int ES     = 1;
    localparam int MANT_W = WIDTH - ES - 2;
    localparam int EXP_W  = (ES > 0) ? ES : 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] posit = '0;
    logic             in_ready;
    logic             out_valid;
    sign_t            sign;
    logic signed [7:0] regime;
    logic [EXP_W-1:0] exponent;
    logic [MANT_W-1:0] mantissa;
    logic             is_zero;
    logic             is_nar;
`ifdef POSIT_DEC_SCALE_EN
    logic signed [8+ES-1:0] scale;
`endif

    posit_decoder_pipe #(.WIDTH(WIDTH), .ES(ES)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .posit(posit),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign(sign), .regime(regime), .exponent(exponent), .mantissa(mantissa),
`ifdef POSIT_DEC_SCALE_EN
        .scale(scale),
`endif
        .is_zero(is_zero), .is_nar(is_nar)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_out  = 0;

    typedef struct {
        int sign; int regime; int exponent; int mant; int zero; int nar; int scale;
    } fields_t;

    fields_t sb[$];
    fields_t held;
    logic    held_v = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk the bits below the sign as a queue, consuming run, terminator,
    // exponent and fraction in turn; missing bits read as 0.
    function automatic fields_t model(input logic [WIDTH-1:0] p);
        fields_t f = '{default: 0};
        int      bits[$];
        int      a, first, r;
        if (p == 0) begin
            f.zero = 1;
        end else if (p == (1 << (WIDTH - 1))) begin
            f.nar = 1;
        end else begin
            f.sign = p[WIDTH-1];
            a = p[WIDTH-1] ? ((1 << WIDTH) - int'(p)) : int'(p);
            for (int i = WIDTH - 2; i >= 0; i--) bits.push_back((a >> i) & 1);
            first = bits[0];
            r = 0;
            while (bits.size() > 0 && bits[0] == first) begin
                void'(bits.pop_front());
                r++;
            end
            if (bits.size() > 0) void'(bits.pop_front());
            f.regime = first ? r - 1 : -r;
            for (int k = 0; k < ES; k++)
                f.exponent = f.exponent * 2 + ((bits.size() > 0) ? bits.pop_front() : 0);
            f.mant = 1;
            for (int k = 0; k < MANT_W - 1; k++)
                f.mant = f.mant * 2 + ((bits.size() > 0) ? bits.pop_front() : 0);
            f.scale = f.regime * (1 << ES) + f.exponent;
        end
        return f;
    endfunction

    function automatic fields_t sample();
        fields_t f;
        f.sign     = int'(sign);
        f.regime   = int'(regime);
        f.exponent = int'(exponent);
        f.mant     = int'(mantissa);
        f.zero     = int'(is_zero);
        f.nar      = int'(is_nar);
`ifdef POSIT_DEC_SCALE_EN
        f.scale    = int'(scale);
`else
        f.scale    = 0;
`endif
        return f;
    endfunction

    task automatic compare(input string tag, input fields_t act, input fields_t exp);
        check({tag, "_sign"},     act.sign,     exp.sign);
        check({tag, "_regime"},   act.regime,   exp.regime);
        check({tag, "_exponent"}, act.exponent, exp.exponent);
        check({tag, "_mantissa"}, act.mant,     exp.mant);
        check({tag, "_is_zero"},  act.zero,     exp.zero);
        check({tag, "_is_nar"},   act.nar,      exp.nar);
`ifdef POSIT_DEC_SCALE_EN
        check({tag, "_scale"},    act.scale,    exp.scale);
`endif
    endtask

    // Monitor: inputs/outputs only change just after the rising edge, so the falling
    // edge sees exactly what the next rising edge will transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            held_v = 1'b0;
        end else begin
            if (in_valid && in_ready) sb.push_back(model(posit));
            if (held_v) begin
                check("hold_out_valid", out_valid, 1);
                compare("hold", sample(), held);
            end
            held_v = out_valid && !out_ready;
            if (held_v) held = sample();
            if (out_valid && out_ready) begin
                n_out++;
                check("out_expected", sb.size() > 0, 1);
                if (sb.size() > 0) compare("out", sample(), sb.pop_front());
            end
        end
    end

    task automatic send_word(input logic [WIDTH-1:0] p);
        @(posedge clk); #1;
        in_valid = 1'b1;
        posit    = p;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        posit    = '0;
        @(negedge clk);
        check("latency_cycle1_out_valid", out_valid, 0);
        @(negedge clk);
        check("latency_cycle2_out_valid", out_valid, 1);
    endtask

    task automatic pin(input string tag, input logic [WIDTH-1:0] p,
                       input int s, input int r, input int e, input int m,
                       input int z, input int n, input int sc);
        fields_t exp_f;
        exp_f = '{sign: s, regime: r, exponent: e, mant: m, zero: z, nar: n, scale: sc};
        check({tag, "_sign"},   model(p).sign,     exp_f.sign);
        check({tag, "_regime"}, model(p).regime,   exp_f.regime);
        check({tag, "_exp"},    model(p).exponent, exp_f.exponent);
        check({tag, "_mant"},   model(p).mant,     exp_f.mant);
        check({tag, "_zero"},   model(p).zero,     exp_f.zero);
        check({tag, "_nar"},    model(p).nar,      exp_f.nar);
        check({tag, "_scale"},  model(p).scale,    exp_f.scale);
    endtask

    logic [WIDTH-1:0] vec [8] = '{8'h40, 8'h6A, 8'h96, 8'h01, 8'h7F, 8'h00, 8'h80, 8'h40};
    logic [WIDTH-1:0] stream [4] = '{8'h40, 8'h6A, 8'h01, 8'h7F};
    logic             exp_rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int idx;
        int n0;
        bit drained;

        // Model pinned against hand-decoded values
        pin("model_40", 8'h40, 0,  0, 0, 5'b10000, 0, 0,   0);
        pin("model_6A", 8'h6A, 0,  1, 1, 5'b10100, 0, 0,   3);
        pin("model_96", 8'h96, 1,  1, 1, 5'b10100, 0, 0,   3);
        pin("model_01", 8'h01, 0, -6, 0, 5'b10000, 0, 0, -12);
        pin("model_7F", 8'h7F, 0,  6, 0, 5'b10000, 0, 0,  12);
        pin("model_00", 8'h00, 0,  0, 0, 0,        1, 0,   0);
        pin("model_80", 8'h80, 0,  0, 0, 0,        0, 1,   0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        compare("reset", sample(), '{default: 0});
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vec[i]) send_word(vec[i]);

        // Back-to-back stream with a 3-cycle downstream stall
        @(posedge clk); #1;
        n0 = n_out;
        idx = 0;
        drained = 1'b0;
        for (int c = 0; c < 30 && !drained; c++) begin
            in_valid  = (idx < 4);
            posit     = (idx < 4) ? stream[idx] : '0;
            out_ready = !(c >= 3 && c <= 5);
            @(negedge clk);
            if (c < 7) check($sformatf("stream_in_ready_c%0d", c), in_ready, exp_rdy[c]);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            drained = (idx == 4) && (sb.size() == 0) && !out_valid;
        end
        in_valid = 1'b0;
        check("stream_drained", drained, 1);
        check("stream_out_count", n_out - n0, 4);

        // Reset with two words in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        posit     = 8'h01;
        @(posedge clk); #1;
        posit     = 8'h7F;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        check("pre_reset_out_valid", out_valid, 1);
        check("pre_reset_in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("reset_mid_out_valid", out_valid, 0);
        check("reset_mid_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        n0 = n_out;
        send_word(8'h6A);
        repeat (4) @(negedge clk);
        check("post_reset_out_count", n_out - n0, 1);
        check("post_reset_idle_out_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
